// File: rtl/muldiv_pkg.sv
// Shared types and the cycle-count model for the HI/LO multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } muldiv_state_e;

  // Number of BUSY cycles an operation occupies (the hazard unit uses the same model).
  function automatic int muldiv_cycles(muldiv_op_e op, int w, int mul_bits);
    return (op == DIV || op == DIVU) ? w : w / mul_bits;
  endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor on a W+1-bit path and keep or restore.
module muldiv_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] partial_rem,
  input  logic             dividend_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             quot_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted  = {partial_rem, dividend_bit};
  assign diff     = shifted - {1'b0, divisor};
  assign quot_bit = (shifted >= {1'b0, divisor});
  // When the trial succeeds the difference is below the divisor, so W bits suffice.
  assign next_rem = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide engine with start/busy/done handshake.
// A single 2*WIDTH accumulator serves both operations: the upper half holds the
// running partial product / remainder, the lower half the unconsumed multiplier /
// dividend bits (which become the quotient as the divide proceeds).
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PW    = WIDTH + MUL_BITS;

  muldiv_state_e      state_reg, state_next;
  muldiv_op_e         op_reg, op_in;
  logic [WIDTH-1:0]   opnd_b_reg, a_raw_reg, hi_reg, lo_reg;
  logic [2*WIDTH-1:0] acc_reg, acc_next, mul_acc, div_acc, prod;
  logic [CNT_W-1:0]   cnt_reg;
  logic               neg_res_reg, neg_rem_reg, div_zero_reg;

  logic               accept, signed_in, a_neg, b_neg, is_div, last_step;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem, div_rem, hi_next, lo_next;
  logic               div_qbit;
  logic [PW-1:0]      mul_partial, mul_upper;

  assign op_in     = muldiv_op_e'(op_i);
  assign accept    = (state_reg == IDLE) && start_i && !flush_i;
  assign signed_in = (op_in == MULT) || (op_in == DIV);
  assign a_neg     = signed_in && a_i[WIDTH-1];
  assign b_neg     = signed_in && b_i[WIDTH-1];
  assign a_mag     = a_neg ? -a_i : a_i;
  assign b_mag     = b_neg ? -b_i : b_i;
  assign is_div    = (op_reg == DIV) || (op_reg == DIVU);
  assign last_step = (cnt_reg == CNT_W'(muldiv_cycles(op_reg, WIDTH, MUL_BITS) - 1));

  // Multiply step: add multiplicand times the low MUL_BITS multiplier bits, shift right.
  always_comb begin
    mul_partial = '0;
    for (int i = 0; i < MUL_BITS; i++) begin
      if (acc_reg[i]) mul_partial = mul_partial + (PW'(opnd_b_reg) << i);
    end
    mul_upper = PW'(acc_reg[2*WIDTH-1:WIDTH]) + mul_partial;
    mul_acc   = {mul_upper, acc_reg[WIDTH-1:MUL_BITS]};
  end

  muldiv_div_step #(.WIDTH(WIDTH)) u_div_step (
    .partial_rem  (acc_reg[2*WIDTH-1:WIDTH]),
    .dividend_bit (acc_reg[WIDTH-1]),
    .divisor      (opnd_b_reg),
    .next_rem     (div_rem),
    .quot_bit     (div_qbit)
  );

  assign div_acc  = {div_rem, acc_reg[WIDTH-2:0], div_qbit};
  assign acc_next = is_div ? div_acc : mul_acc;

  // Sign correction of the final step, with the divide-by-zero pattern taking priority.
  always_comb begin
    prod    = neg_res_reg ? -acc_next : acc_next;
    quot    = neg_res_reg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
    rem     = neg_rem_reg ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];
    hi_next = prod[2*WIDTH-1:WIDTH];
    lo_next = prod[WIDTH-1:0];
    if (is_div) begin
      hi_next = div_zero_reg ? a_raw_reg : rem;
      lo_next = div_zero_reg ? '1 : quot;
    end
  end

  // Next-state logic; a flush only aborts work still in flight.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (flush_i) state_next = IDLE;
               else if (last_step) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, operand latch, iteration and result commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      op_reg       <= MULT;
      opnd_b_reg   <= '0;
      a_raw_reg    <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      neg_res_reg  <= 1'b0;
      neg_rem_reg  <= 1'b0;
      div_zero_reg <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg       <= op_in;
        opnd_b_reg   <= b_mag;
        a_raw_reg    <= a_i;
        acc_reg      <= {{WIDTH{1'b0}}, a_mag};
        cnt_reg      <= '0;
        neg_res_reg  <= a_neg ^ b_neg;
        neg_rem_reg  <= a_neg;
        div_zero_reg <= (b_i == '0);
      end else if (state_reg == BUSY && !flush_i) begin
        acc_reg <= acc_next;
        cnt_reg <= cnt_reg + 1'b1;
        if (last_step) begin
          hi_reg <= hi_next;
          lo_reg <= lo_next;
        end
      end
    end
  end

  assign busy_o  = (state_reg == BUSY);
  assign done_o  = (state_reg == DONE);
  assign stall_o = accept || busy_o;
  assign hi_o    = hi_reg;
  assign lo_o    = lo_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (MUL_BITS = 2, 1 and 4 instances).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, flush_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i;
  logic        busy2, done2, stall2, busy1, done1, stall1, busy4, done4, stall4;
  logic [31:0] hi2, lo2, hi1, lo1, hi4, lo4;

  int checks = 0;
  int errors = 0;
  int cyc, stalls, c1, c2, c4, ndone, first_done;

  always #5 clk_i = ~clk_i;

  muldiv_unit #(.WIDTH(32), .MUL_BITS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy2), .done_o(done2), .stall_o(stall2), .hi_o(hi2), .lo_o(lo2)
  );
  muldiv_unit #(.WIDTH(32), .MUL_BITS(1)) dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy1), .done_o(done1), .stall_o(stall1), .hi_o(hi1), .lo_o(lo1)
  );
  muldiv_unit #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .flush_i(flush_i), .busy_o(busy4), .done_o(done4), .stall_o(stall4), .hi_o(hi4), .lo_o(lo4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge: present a one-cycle request, return just after the accept edge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    @(posedge clk_i);
    #1 start_i = 1'b0; op_i = 2'b00; a_i = 32'h0; b_i = 32'h0;
  endtask

  // Count negedges until done on the MUL_BITS=2 instance (bounded).
  task automatic wait_done(output int n_done, output int n_stall);
    n_done = 0; n_stall = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk_i);
      if (done2) begin n_done = n; break; end
      if (stall2) n_stall++;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; flush_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
    check("rst_busy", 64'(busy2), 64'd0);
    check("rst_done", 64'(done2), 64'd0);
    check("rst_hilo", {hi2, lo2}, 64'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("rst_stall", 64'(stall2), 64'd0);

    // MULT -3 * 5
    issue(2'b00, 32'hFFFFFFFD, 32'd5);
    wait_done(cyc, stalls);
    check("mult_cycles", 64'(cyc), 64'd17);
    check("mult_stalls", 64'(stalls), 64'd16);
    check("mult_hilo", {hi2, lo2}, 64'hFFFFFFFF_FFFFFFF1);
    check("done_nostall", 64'(stall2), 64'd0);
    @(negedge clk_i);
    check("done_pulse", 64'(done2), 64'd0);
    check("hold_hilo", {hi2, lo2}, 64'hFFFFFFFF_FFFFFFF1);
    idle_cycles(40);

    // MULTU max * max on all three rates
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    c1 = 0; c2 = 0; c4 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk_i);
      if (done1 && c1 == 0) c1 = n;
      if (done2 && c2 == 0) c2 = n;
      if (done4 && c4 == 0) c4 = n;
    end
    check("multu_cyc_mb2", 64'(c2), 64'd17);
    check("multu_cyc_mb1", 64'(c1), 64'd33);
    check("multu_cyc_mb4", 64'(c4), 64'd9);
    check("multu_mb2", {hi2, lo2}, 64'hFFFFFFFE_00000001);
    check("multu_mb1", {hi1, lo1}, 64'hFFFFFFFE_00000001);
    check("multu_mb4", {hi4, lo4}, 64'hFFFFFFFE_00000001);

    // Signed and unsigned divides
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_done(cyc, stalls);
    check("div_cycles", 64'(cyc), 64'd33);
    check("div_m7_2", {hi2, lo2}, 64'hFFFFFFFF_FFFFFFFD);
    idle_cycles(2);
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_done(cyc, stalls);
    check("div_ovf", {hi2, lo2}, 64'h00000000_80000000);
    idle_cycles(2);
    issue(2'b11, 32'd100, 32'd0);
    wait_done(cyc, stalls);
    check("divu_zero", {hi2, lo2}, 64'h00000064_FFFFFFFF);
    idle_cycles(2);

    // Flush mid-divide
    issue(2'b00, 32'd6, 32'd7);
    wait_done(cyc, stalls);
    check("mult_6x7", {hi2, lo2}, 64'd42);
    idle_cycles(40);
    issue(2'b10, 32'd9, 32'd3);
    idle_cycles(9);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    @(negedge clk_i);
    check("flush_busy", 64'(busy2), 64'd0);
    check("flush_done", 64'(done2), 64'd0);
    check("flush_hilo", {hi2, lo2}, 64'd42);
    issue(2'b01, 32'd2, 32'd3);
    @(negedge clk_i);
    check("reaccept_busy", 64'(busy2), 64'd1);
    wait_done(cyc, stalls);
    check("reaccept_cyc", 64'(cyc + 1), 64'd17);
    check("reaccept_hilo", {hi2, lo2}, 64'd6);
    idle_cycles(40);

    // Reset mid-divide, then reset together with start
    issue(2'b10, 32'd9, 32'd3);
    idle_cycles(5);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_busy", 64'(busy2), 64'd0);
    check("rstmid_hilo", {hi2, lo2}, 64'd0);
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk_i);
      if (done2) ndone++;
    end
    check("rstmid_nodone", 64'(ndone), 64'd0);
    rst_i = 1'b1; start_i = 1'b1; op_i = 2'b10; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk_i);
    #1 rst_i = 1'b0; start_i = 1'b0;
    @(negedge clk_i);
    check("rststart_busy", 64'(busy2), 64'd0);
    check("rststart_stall", 64'(stall2), 64'd0);
    check("rststart_done", 64'(done2), 64'd0);

    // start held high: one operation per accept, DONE cycle between requests
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd9; b_i = 32'd3;
    @(posedge clk_i);
    ndone = 0; first_done = 0;
    for (int n = 1; n <= 68; n++) begin
      @(negedge clk_i);
      if (done2) begin
        ndone++;
        if (first_done == 0) first_done = n;
      end
      if (n == 34) begin
        check("held_gap_busy", 64'(busy2), 64'd0);
        check("held_gap_stall", 64'(stall2), 64'd1);
      end
      if (n == 35) check("held_rebusy", 64'(busy2), 64'd1);
    end
    start_i = 1'b0;
    check("held_first", 64'(first_done), 64'd33);
    check("held_ndone", 64'(ndone), 64'd2);
    check("held_hilo", {hi2, lo2}, 64'd3);
    idle_cycles(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised HI/LO arithmetic unit for the EX stage. It executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands and writes a 2×WIDTH HI/LO result. It replaces the fixed-latency, multiply-only IP path with an in-house sequential engine that adds division, a configurable multiply rate and a start/busy/done handshake. The EX stage drives it from decoded ALU control and holds the pipeline on `stall_o`.

## Interface
- `WIDTH`, 32: operand width; must be even and ≥ 8.
- `MUL_BITS`, 2: multiplier bits retired per cycle; one of 1, 2, 4, and must divide WIDTH.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  request; accepted only in IDLE when `flush_i`=0.
- `op_i`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a_i`, `b_i`  in  WIDTH  rs / rt operands; sampled only on the accept edge.
- `flush_i`  in  1  EX flush or exception abort.
- `busy_o`  out  1  high while in BUSY.
- `done_o`  out  1  one-cycle pulse; `hi_o`/`lo_o` are valid from this cycle onward.
- `stall_o`  out  1  combinational: (IDLE & `start_i` & ~`flush_i`) | BUSY.
- `hi_o`, `lo_o`  out  WIDTH  result registers; hold their value until the next `done_o`.

## Operation
- FSM states:
  - IDLE→BUSY on accept: latch op, operand magnitudes and sign flags; clear the step counter.
  - BUSY→DONE after the last step: the result is written to `hi_o`/`lo_o` on this edge.
  - DONE→IDLE unconditionally.
- `start_i` in BUSY or DONE is ignored.
- Signed ops use magnitudes internally.
  - MULT: the product is negated if the operand signs differ.
  - DIV: the quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Multiply is shift-add on a 2×WIDTH accumulator, MUL_BITS per cycle.
  - MULT/MULTU: `hi_o` = product[2W-1:W], `lo_o` = product[W-1:0].
- Divide is restoring, one quotient bit per cycle.
  - DIV/DIVU: `lo_o` = quotient, `hi_o` = remainder.
- Divide by zero completes normally with no exception:
  - `lo_o` = all ones, `hi_o` = `a_i`, for both DIV and DIVU.
  - This pattern is forced at completion, independent of sign correction.
- Signed overflow: most-negative / -1 gives `lo_o` = most-negative, `hi_o` = 0 (W-bit truncation).
- Intermediate arithmetic is one bit wider than the operand it serves (W+1 subtractor), so no carry is lost.

## Timing
- Reset values: state IDLE, `busy_o`=0, `done_o`=0, `hi_o`=0, `lo_o`=0, counter 0.
- Accept at edge T0. BUSY spans W/MUL_BITS cycles for multiply and W cycles for divide.
- `done_o` is high in the cycle after the last BUSY cycle.
  - Defaults: MULT `done_o` at T0+17, DIV `done_o` at T0+33.
- `stall_o` is low in the DONE cycle, so the consumer captures `hi_o`/`lo_o` while `done_o`=1.
- `flush_i`=1 in BUSY: next state IDLE, no `done_o`, `hi_o`/`lo_o` unchanged.
- `flush_i` in DONE has no effect; the result is already committed.
- `flush_i` with `start_i` in IDLE: no accept.
- `rst_i` overrides everything, including mid-operation and same-cycle `start_i`/`flush_i`.
- `op_i`/`a_i`/`b_i` may change freely after the accept edge.

## Structure
- `muldiv_pkg`:
  - `muldiv_op_e` (MULT, MULTU, DIV, DIVU) and `muldiv_state_e` (IDLE, BUSY, DONE).
  - Cycle-count function `muldiv_cycles(op, W, MUL_BITS)`, shared with the hazard unit's stall model.
- One sub-module, `muldiv_div_step`: combinational single restoring step (W+1-bit subtract and select). It is instantiated once; the multiply step stays inline.

## Test plan
- MULT a=0xFFFFFFFD (-3), b=5 → `hi_o`=0xFFFFFFFF, `lo_o`=0xFFFFFFF1; `done_o` exactly 17 cycles after accept; `stall_o` high for 16 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi_o`=0xFFFFFFFE, `lo_o`=0x00000001; repeat with MUL_BITS=1 and 4 → same result, `done_o` at +33 and +9.
- DIV -7/2 → `lo_o`=0xFFFFFFFD, `hi_o`=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0. DIVU 100/0 → `lo_o`=0xFFFFFFFF, `hi_o`=0x64.
- Complete MULT 6×7 (`lo_o`=42); start DIV 9/3; assert `flush_i` at BUSY cycle 10:
  - no `done_o`; `hi_o`/`lo_o` stay 0/42; `busy_o`=0 next cycle.
  - A new request is then accepted immediately.
- `rst_i` pulsed mid-DIV, and again together with `start_i` → all outputs 0, IDLE, no `done_o`.
- `start_i` held high through BUSY and DONE → exactly one operation per accept. Back-to-back requests are separated by the DONE cycle.
